// File: rtl/register_file_if.sv
// ----------------------------------------------------------------------------
// register_file_if
//   Operand-fetch / write-back bus between decode, the ALU and register_file.
//   The master (decode/write-back side) supplies two read addresses plus one
//   write command. The slave (register_file) returns the two operands.
//
//   Signals
//     r1, r2    read port 1/2 register index             (master -> slave)
//     wr        write register index                     (master -> slave)
//     wd        write data                               (master -> slave)
//     regwrite  write enable, active-high                (master -> slave)
//     data1     contents of register r1                  (slave  -> master)
//     data2     contents of register r2                  (slave  -> master)
// ----------------------------------------------------------------------------
interface register_file_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic [ADDR_W-1:0] r1;
   logic [ADDR_W-1:0] r2;
   logic [ADDR_W-1:0] wr;
   logic [DATA_W-1:0] wd;
   logic              regwrite;
   logic [DATA_W-1:0] data1;
   logic [DATA_W-1:0] data2;

   modport master (
      output r1, r2, wr, wd, regwrite,
      input  data1, data2
   );

   modport slave (
      input  r1, r2, wr, wd, regwrite,
      output data1, data2
   );
endinterface

// File: rtl/register_file.sv
// ----------------------------------------------------------------------------
// register_file
//   Dual-read, single-write general-purpose register file for the RISC
//   datapath. Two operands are read combinationally (zero-cycle latency) and
//   one result is written back on the rising clock edge. Register 0 always
//   reads as zero and ignores writes.
//
//   Ports
//     clk   in  1   single clock, rising-edge
//     res   in  1   reset, synchronous, active-low; clears every register and
//                   takes priority over a write on the same edge
//     bus   register_file_if.slave
//             r1/r2 read addresses, wr/wd/regwrite write command,
//             data1/data2 read data
//
//   Parameters
//     DATA_W    register / data width
//     ADDR_W    register index width
//     NUM_REGS  number of registers, must equal 2**ADDR_W
//
//   Build option
//     REGFILE_BYPASS_EN  when defined, a read of the register being written in
//                        the current cycle returns wd combinationally
//                        (write-through forwarding). When undefined, such a
//                        read returns the old contents until the edge.
// ----------------------------------------------------------------------------
module register_file #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_REGS = 32
) (
   input  logic            clk,
   input  logic            res,
   register_file_if.slave  bus
);

   localparam int NUM_RD = 2;

   logic [DATA_W-1:0] r_regs [NUM_REGS];

   logic [ADDR_W-1:0] w_raddr [NUM_RD];
   logic [DATA_W-1:0] w_rdata [NUM_RD];
   logic              w_wr_en;

   // Writes to register 0 are dropped here so that entry stays at its reset
   // value; the read path additionally forces index 0 to zero.
   assign w_wr_en = bus.regwrite && (bus.wr != '0);

   always_ff @(posedge clk) begin
      if (!res) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_regs[i] <= '0;
         end
      end else if (w_wr_en) begin
         r_regs[bus.wr] <= bus.wd;
      end
   end

   assign w_raddr[0] = bus.r1;
   assign w_raddr[1] = bus.r2;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_RD; gi++) begin : g_rd_port
`ifdef REGFILE_BYPASS_EN
         // Forward the in-flight write only when it will actually land:
         // not during reset and never for register 0.
         assign w_rdata[gi] = (w_raddr[gi] == '0)                   ? '0     :
                              (res && w_wr_en && (bus.wr == w_raddr[gi])) ? bus.wd :
                                                                      r_regs[w_raddr[gi]];
`else
         assign w_rdata[gi] = (w_raddr[gi] == '0) ? '0 : r_regs[w_raddr[gi]];
`endif
      end
   endgenerate

   assign bus.data1 = w_rdata[0];
   assign bus.data2 = w_rdata[1];

endmodule

// File: tb/tb_register_file.sv
// ----------------------------------------------------------------------------
// tb_register_file
//   Directed-vector bench for register_file. Inputs change 1 time unit after
//   a rising edge and outputs are sampled 1 time unit after that, well away
//   from the active edge. Expected values are hand-computed constants.
//   Define REGFILE_BYPASS_EN for both DUT and bench to exercise forwarding.
// ----------------------------------------------------------------------------
module tb_register_file;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;

   logic clk;
   logic res;
   int   n_vec;
   int   n_miss;

   register_file_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_bus ();

   register_file #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .NUM_REGS (32)
   ) u_dut (
      .clk (clk),
      .res (res),
      .bus (u_bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [DATA_W-1:0] got,
                            input logic [DATA_W-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end else begin
         $display("ok   %s got=%h", tag, got);
      end
   endtask

   // Advance past the next rising edge, leaving 1 unit of hold margin.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Let combinational reads settle before sampling.
   task automatic settle();
      #1;
   endtask

   initial begin
      n_vec            = 0;
      n_miss           = 0;
      res              = 1'b0;
      u_bus.r1         = '0;
      u_bus.r2         = '0;
      u_bus.wr         = '0;
      u_bus.wd         = '0;
      u_bus.regwrite   = 1'b0;

      // 1. Reset for two edges, then every register reads zero on both ports.
      tick();
      tick();
      res = 1'b1;
      for (int i = 0; i < 32; i++) begin
         u_bus.r1 = 5'(i);
         u_bus.r2 = 5'(31 - i);
         settle();
         check_val($sformatf("rst_d1_r%0d", i), u_bus.data1, 32'd0);
         check_val($sformatf("rst_d2_r%0d", 31 - i), u_bus.data2, 32'd0);
      end

      // 2. Two back-to-back writes, then read both on separate ports.
      u_bus.regwrite = 1'b1;
      u_bus.wr       = 5'd14;
      u_bus.wd       = 32'd21;
      tick();
      u_bus.wr       = 5'd15;
      u_bus.wd       = 32'd12;
      tick();
      u_bus.regwrite = 1'b0;
      u_bus.r1       = 5'd14;
      u_bus.r2       = 5'd15;
      settle();
      check_val("wr_r14_d1", u_bus.data1, 32'd21);
      check_val("wr_r15_d2", u_bus.data2, 32'd12);

      // Both ports on the same register.
      u_bus.r2 = 5'd14;
      settle();
      check_val("same_d1", u_bus.data1, 32'd21);
      check_val("same_d2", u_bus.data2, 32'd21);

      // 3. regwrite low: no write.
      u_bus.wr = 5'd14;
      u_bus.wd = 32'd99;
      tick();
      check_val("nowr_r14", u_bus.data1, 32'd21);

      // 4. Write to register 0 is discarded; other registers untouched.
      u_bus.regwrite = 1'b1;
      u_bus.wr       = 5'd0;
      u_bus.wd       = 32'hDEADBEEF;
      tick();
      u_bus.regwrite = 1'b0;
      u_bus.r1       = 5'd0;
      u_bus.r2       = 5'd15;
      settle();
      check_val("r0_d1", u_bus.data1, 32'd0);
      check_val("r0_keep_r15", u_bus.data2, 32'd12);

      // Top register, all-ones data.
      u_bus.regwrite = 1'b1;
      u_bus.wr       = 5'd31;
      u_bus.wd       = 32'hFFFFFFFF;
      tick();
      u_bus.regwrite = 1'b0;
      u_bus.r2       = 5'd31;
      settle();
      check_val("r31_d2", u_bus.data2, 32'hFFFFFFFF);

      // Pending write to register 0 is never forwarded.
      u_bus.regwrite = 1'b1;
      u_bus.wr       = 5'd0;
      u_bus.wd       = 32'h12345678;
      u_bus.r1       = 5'd0;
      settle();
      check_val("r0_nofwd", u_bus.data1, 32'd0);
      tick();
      u_bus.regwrite = 1'b0;

      // 5. Reset beats a write on the same edge.
      res            = 1'b0;
      u_bus.regwrite = 1'b1;
      u_bus.wr       = 5'd14;
      u_bus.wd       = 32'd7;
      tick();
      res            = 1'b1;
      u_bus.regwrite = 1'b0;
      u_bus.r1       = 5'd14;
      u_bus.r2       = 5'd31;
      settle();
      check_val("rstwin_r14", u_bus.data1, 32'd0);
      check_val("rstwin_r31", u_bus.data2, 32'd0);

      // 6. Read-during-write on register 5 (reg5 is 0 after the reset above).
      u_bus.r1       = 5'd5;
      u_bus.r2       = 5'd5;
      u_bus.wr       = 5'd5;
      u_bus.wd       = 32'd33;
      u_bus.regwrite = 1'b1;
      settle();
`ifdef REGFILE_BYPASS_EN
      check_val("rdw_pre_d1", u_bus.data1, 32'd33);
      check_val("rdw_pre_d2", u_bus.data2, 32'd33);
`else
      check_val("rdw_pre_d1", u_bus.data1, 32'd0);
      check_val("rdw_pre_d2", u_bus.data2, 32'd0);
`endif
      tick();
      u_bus.regwrite = 1'b0;
      settle();
      check_val("rdw_post_d1", u_bus.data1, 32'd33);
      check_val("rdw_post_d2", u_bus.data2, 32'd33);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
